// File: rtl/pci_master_initiator.sv
// PCI bus-master initiator: requests the bus, runs one address phase and a
// burst of up to MAX_BURST data phases, and reports the outcome on a simple
// start/done user interface.
module pci_master_initiator #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_BURST      = 8,
  parameter int unsigned DEVSEL_TIMEOUT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        cmd,
  input  logic [31:0]       addr,
  input  logic [3:0]        len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [3:0]        beats_done,
  output logic              req_low,
  input  logic              gnt_low,
  input  logic              frame_in_low,
  input  logic              irdy_in_low,
  output logic              frame_low,
  output logic              irdy_low,
  input  logic              trdy_low,
  input  logic              devsel_low,
  input  logic              stop_low,
  output logic [DATA_W-1:0] ad_out,
  input  logic [DATA_W-1:0] ad_in,
  output logic              ad_oe,
  output logic [3:0]        cbe_low
);

  localparam int unsigned CNT_W = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_DATA, S_LAST, S_TURN
  } state_t;

  state_t            state;
  logic [3:0]        cmd_q;
  logic [31:0]       addr_q;
  logic [3:0]        remaining;
  logic [CNT_W-1:0]  devsel_cnt;
  logic [DATA_W-1:0] ad_q;
  logic [3:0]        len_eff;
  logic              is_write;
  logic              beat_c;
  logic              stop_c;

  // Requested burst length clamped into 1..MAX_BURST
  always_comb begin
    len_eff = len;
    if (len == 4'd0) begin
      len_eff = 4'd1;
    end else if (len > 4'(MAX_BURST)) begin
      len_eff = 4'(MAX_BURST);
    end
  end

  assign is_write  = cmd_q[0];
  assign beat_c    = (state == S_DATA) && !irdy_low && !trdy_low && !devsel_low;
  assign stop_c    = (state == S_DATA) && !stop_low && !devsel_low;
  assign wdata_ack = beat_c && is_write;
  assign ad_out    = ((state == S_DATA) && is_write) ? wdata : ad_q;

  // Transaction FSM with registered bus and user outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_q       <= 4'h0;
      addr_q      <= 32'h0;
      remaining   <= 4'd0;
      devsel_cnt  <= '0;
      ad_q        <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= 2'b00;
      beats_done  <= 4'd0;
      req_low     <= 1'b1;
      frame_low   <= 1'b1;
      irdy_low    <= 1'b1;
      ad_oe       <= 1'b0;
      cbe_low     <= 4'hF;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cmd_q      <= cmd;
            addr_q     <= addr;
            remaining  <= len_eff;
            beats_done <= 4'd0;
            status     <= 2'b00;
            busy       <= 1'b1;
            req_low    <= 1'b0;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          // Take the bus only when granted and nobody else is still on it
          if (!gnt_low && frame_in_low && irdy_in_low) begin
            req_low    <= 1'b1;
            frame_low  <= 1'b0;
            ad_oe      <= 1'b1;
            ad_q       <= DATA_W'(addr_q);
            cbe_low    <= cmd_q;
            devsel_cnt <= '0;
            state      <= S_ADDR;
          end
        end
        S_ADDR: begin
          irdy_low  <= 1'b0;
          cbe_low   <= 4'h0;
          ad_oe     <= is_write;
          frame_low <= !(remaining > 4'd1);
          state     <= S_DATA;
        end
        S_DATA: begin
          if (beat_c) begin
            beats_done <= beats_done + 4'd1;
            remaining  <= remaining - 4'd1;
            devsel_cnt <= '0;
            if (!is_write) begin
              rdata       <= ad_in;
              rdata_valid <= 1'b1;
            end
            if (remaining == 4'd1) begin
              frame_low <= 1'b1;
              irdy_low  <= 1'b1;
              ad_oe     <= 1'b0;
              cbe_low   <= 4'hF;
              done      <= 1'b1;
              status    <= 2'b00;
              state     <= S_TURN;
            end else if (stop_c) begin
              frame_low <= 1'b1;
              ad_oe     <= 1'b0;
              status    <= 2'b10;
              state     <= S_LAST;
            end else begin
              frame_low <= !(remaining > 4'd2);
            end
          end else if (stop_c) begin
            frame_low <= 1'b1;
            ad_oe     <= 1'b0;
            status    <= 2'b10;
            state     <= S_LAST;
          end else if (devsel_low) begin
            // No target claimed the cycle: count toward master abort
            if (devsel_cnt == CNT_W'(DEVSEL_TIMEOUT - 1)) begin
              frame_low <= 1'b1;
              ad_oe     <= 1'b0;
              status    <= 2'b01;
              state     <= S_LAST;
            end else begin
              devsel_cnt <= devsel_cnt + CNT_W'(1);
            end
          end else begin
            devsel_cnt <= '0;
          end
        end
        S_LAST: begin
          frame_low <= 1'b1;
          irdy_low  <= 1'b1;
          ad_oe     <= 1'b0;
          cbe_low   <= 4'hF;
          done      <= 1'b1;
          state     <= S_TURN;
        end
        S_TURN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_master_initiator.sv
// Bench for pci_master_initiator: table of transactions against an arbiter
// and target model, with read/write data checked through scoreboard queues.
module tb_pci_master_initiator;

  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        cmd;
  logic [31:0]       addr;
  logic [3:0]        len;
  logic [DATA_W-1:0] wdata;
  logic              wdata_ack;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              busy;
  logic              done;
  logic [1:0]        status;
  logic [3:0]        beats_done;
  logic              req_low;
  logic              gnt_low;
  logic              frame_in_low;
  logic              irdy_in_low;
  logic              frame_low;
  logic              irdy_low;
  logic              trdy_low;
  logic              devsel_low;
  logic              stop_low;
  logic [DATA_W-1:0] ad_out;
  logic [DATA_W-1:0] ad_in;
  logic              ad_oe;
  logic [3:0]        cbe_low;

  pci_master_initiator #(.DATA_W(DATA_W), .MAX_BURST(8), .DEVSEL_TIMEOUT(5)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr(addr), .len(len),
    .wdata(wdata), .wdata_ack(wdata_ack), .rdata(rdata), .rdata_valid(rdata_valid),
    .busy(busy), .done(done), .status(status), .beats_done(beats_done),
    .req_low(req_low), .gnt_low(gnt_low), .frame_in_low(frame_in_low),
    .irdy_in_low(irdy_in_low), .frame_low(frame_low), .irdy_low(irdy_low),
    .trdy_low(trdy_low), .devsel_low(devsel_low), .stop_low(stop_low),
    .ad_out(ad_out), .ad_in(ad_in), .ad_oe(ad_oe), .cbe_low(cbe_low)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [3:0]  len;
    int          len_eff;
    int          gnt_delay;
    int          wait_cyc;
    bit          devsel_en;
    int          stop_beat;
    int          bus_busy;
    logic [31:0] data_base;
    logic [1:0]  exp_status;
    logic [3:0]  exp_beats;
    int          exp_irdy;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  int          mon_len_eff, mon_beat, mon_cur, irdy_cnt, rv_cnt, ack_cnt, done_cnt, wr_idx;
  logic [3:0]  mon_cmd;
  logic [31:0] mon_addr, data_base;
  int          gnt_delay, gcnt;
  bit          tgt_devsel_en, tgt_stopped, tgt_read;
  int          tgt_wait, tgt_wcnt, tgt_beat, tgt_stop_beat;
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arbiter: grant gnt_delay cycles after REQ# falls, release when REQ# rises
  always @(posedge clk) begin
    #1;
    if (rst || req_low) begin
      gcnt    = 0;
      gnt_low = 1'b1;
    end else begin
      if (gcnt >= gnt_delay) gnt_low = 1'b0;
      gcnt++;
    end
  end

  // Target: claims with DEVSEL#, inserts wait states, optionally stops
  always @(posedge clk) begin
    #2;
    trdy_low   = 1'b1;
    devsel_low = 1'b1;
    stop_low   = 1'b1;
    if (!rst && !irdy_low && !tgt_stopped && tgt_devsel_en) begin
      devsel_low = 1'b0;
      if (tgt_wcnt < tgt_wait) begin
        tgt_wcnt++;
      end else begin
        trdy_low = 1'b0;
        tgt_wcnt = 0;
        tgt_beat++;
        ad_in = data_base + 32'(tgt_beat - 1);
        if (tgt_read) rd_q.push_back(ad_in);
        if (tgt_beat == tgt_stop_beat) begin
          stop_low    = 1'b0;
          tgt_stopped = 1'b1;
        end
      end
    end
  end

  // Monitor: address phase, FRAME# per phase, read/write data scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (!irdy_low) irdy_cnt++;
      if (!frame_low && irdy_low) begin
        check("addr_cbe", 32'(cbe_low), 32'(mon_cmd));
        check("addr_ad", ad_out, mon_addr);
      end
      if (!irdy_low && !devsel_low) begin
        mon_cur = mon_beat + 1;
        if (!trdy_low) mon_beat++;
        check("frame_phase", 32'(frame_low), 32'(mon_cur == mon_len_eff));
      end
      if (rdata_valid) begin
        rv_cnt++;
        if (rd_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rdata_unexpected: got %h expected no read data", rdata);
        end else begin
          check("rdata", rdata, rd_q.pop_front());
        end
      end
      if (wdata_ack) begin
        ack_cnt++;
        if (wr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL wdata_ack_unexpected: got ack expected none");
        end else begin
          check("ad_out_wr", ad_out, wr_q.pop_front());
        end
        wr_idx++;
        wdata = data_base + 32'(wr_idx) * 32'h1111_1111;
        wr_q.push_back(wdata);
      end
    end
  end

  task automatic setup(input vec_t v);
    mon_cmd = v.cmd; mon_addr = v.addr; mon_len_eff = v.len_eff; mon_beat = 0;
    irdy_cnt = 0; rv_cnt = 0; ack_cnt = 0; done_cnt = 0; wr_idx = 0;
    data_base = v.data_base; gnt_delay = v.gnt_delay;
    tgt_devsel_en = v.devsel_en; tgt_stopped = 1'b0; tgt_read = !v.cmd[0];
    tgt_wait = v.wait_cyc; tgt_wcnt = 0; tgt_beat = 0; tgt_stop_beat = v.stop_beat;
    rd_q.delete(); wr_q.delete();
    wdata = v.data_base;
    wr_q.push_back(wdata);
    cmd = v.cmd; addr = v.addr; len = v.len;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_ctrl"},
          32'({req_low, frame_low, irdy_low, ad_oe, wdata_ack, rdata_valid, done, busy,
               cbe_low, status, beats_done}),
          32'({8'b1110_0000, 4'hF, 2'b00, 4'd0}));
    check({tag, "_ad_out"}, ad_out, 32'h0);
    check({tag, "_rdata"}, rdata, 32'h0);
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    bit got = 1'b0;
    string t = $sformatf("v%0d", idx);
    setup(v);
    frame_in_low = (v.bus_busy == 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({t, "_busy_start"}, 32'(busy), 32'd1);
    if (v.bus_busy > 0) begin
      repeat (v.bus_busy) @(negedge clk);
      check({t, "_held_in_req"}, 32'({req_low, frame_low}), 32'(2'b01));
      frame_in_low = 1'b1;
    end
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got no done expected done within 200 cycles", t);
    end else begin
      check({t, "_status"}, 32'(status), 32'(v.exp_status));
      check({t, "_beats"}, 32'(beats_done), 32'(v.exp_beats));
      check({t, "_turn_bus"}, 32'({frame_low, irdy_low, ad_oe, cbe_low}), 32'({3'b110, 4'hF}));
      @(negedge clk);
      check({t, "_idle"}, 32'({done, busy}), 32'd0);
      check({t, "_held"}, 32'({status, beats_done}), 32'({v.exp_status, v.exp_beats}));
      check({t, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({t, "_irdy_cycles"}, 32'(irdy_cnt), 32'(v.exp_irdy));
      check({t, "_rd_pulses"}, 32'(rv_cnt), v.cmd[0] ? 32'd0 : 32'(v.exp_beats));
      check({t, "_wr_acks"}, 32'(ack_cnt), v.cmd[0] ? 32'(v.exp_beats) : 32'd0);
      check({t, "_rd_q_empty"}, 32'(rd_q.size()), 32'd0);
    end
  endtask

  function automatic vec_t mk(logic [3:0] c, logic [31:0] a, logic [3:0] l, int le, int gd,
                              int wc, bit de, int sb, int bb, logic [31:0] db,
                              logic [1:0] es, logic [3:0] eb, int ei);
    vec_t v;
    v.cmd = c; v.addr = a; v.len = l; v.len_eff = le; v.gnt_delay = gd; v.wait_cyc = wc;
    v.devsel_en = de; v.stop_beat = sb; v.bus_busy = bb; v.data_base = db;
    v.exp_status = es; v.exp_beats = eb; v.exp_irdy = ei;
    return v;
  endfunction

  initial begin
    vec_t vecs[9];
    bit   seen;
    vecs[0] = mk(4'h6, 32'h1000_0040, 4'd1,  1, 2, 0, 1, 0, 0, 32'hCAFE_0001, 2'b00, 4'd1, 1);
    vecs[1] = mk(4'h7, 32'h2000_0000, 4'd4,  4, 1, 0, 1, 0, 0, 32'hA5A5_0000, 2'b00, 4'd4, 4);
    vecs[2] = mk(4'h6, 32'h3000_0010, 4'd2,  2, 0, 3, 1, 0, 0, 32'h1234_0000, 2'b00, 4'd2, 8);
    vecs[3] = mk(4'h6, 32'h4000_0000, 4'd3,  3, 1, 0, 0, 0, 0, 32'h0000_0000, 2'b01, 4'd0, 6);
    vecs[4] = mk(4'h7, 32'h5000_0000, 4'd8,  8, 1, 0, 1, 3, 0, 32'h5555_0000, 2'b10, 4'd3, 4);
    vecs[5] = mk(4'h2, 32'h6000_0000, 4'd0,  1, 0, 1, 1, 0, 0, 32'h0BAD_0000, 2'b00, 4'd1, 2);
    vecs[6] = mk(4'h3, 32'h7000_0000, 4'd12, 8, 3, 0, 1, 0, 0, 32'h0101_0000, 2'b00, 4'd8, 8);
    vecs[7] = mk(4'h6, 32'h8000_0000, 4'd2,  2, 0, 0, 1, 2, 0, 32'h7777_0000, 2'b00, 4'd2, 2);
    vecs[8] = mk(4'h6, 32'h9000_0000, 4'd1,  1, 0, 0, 1, 0, 6, 32'hBEEF_0000, 2'b00, 4'd1, 1);

    rst = 1'b1; start = 1'b0; cmd = 4'h0; addr = 32'h0; len = 4'd0; wdata = '0;
    gnt_low = 1'b1; frame_in_low = 1'b1; irdy_in_low = 1'b1;
    trdy_low = 1'b1; devsel_low = 1'b1; stop_low = 1'b1; ad_in = '0;
    tgt_devsel_en = 1'b0; tgt_stopped = 1'b0; gnt_delay = 0;
    repeat (3) @(negedge clk);
    reset_check("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i], i);
      @(negedge clk);
    end

    // Reset in the middle of a write burst: no done, everything back to idle
    setup(mk(4'h7, 32'hA000_0000, 4'd8, 8, 0, 1, 1, 0, 0, 32'h3C3C_0000, 2'b00, 4'd0, 0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = !irdy_low;
    end
    check("mid_rst_reached_data", 32'(seen), 32'd1);
    repeat (4) @(negedge clk);
    check("mid_rst_beats_before", 32'(beats_done >= 4'd1), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    reset_check("mid_rst");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    check("mid_rst_stays_idle", 32'({req_low, busy, irdy_low}), 32'(3'b101));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

endmodule
